// File: rtl/regfile_multiport.sv
// Multiport integer register file for the decode stage: NRD read ports, one
// write port, hardwired x0, optional write bypass, pending-write scoreboard.
module regfile_multiport #(
   parameter int XLEN   = 64,
   parameter int NREGS  = 32,
   parameter int AW     = 5,
   parameter int NRD    = 2,
   parameter int BYPASS = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_pending,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic                alloc_en,
   input  logic [AW-1:0]       alloc_addr,
   output logic                init_busy
);

   typedef enum logic {
      ST_CLEAR,
      ST_READY
   } state_t;

   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
   localparam logic          BYP  = (BYPASS != 0);

   state_t            r_state;
   state_t            w_next;
   logic [AW-1:0]     r_cnt;
   logic [XLEN-1:0]   r_regs [NREGS];
   logic [NREGS-1:0]  r_pend;
   logic [NREGS-1:0]  w_pend_nxt;
   logic              w_ready;
   logic              w_last;
   logic              w_wr;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_CLEAR;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_CLEAR: if (w_last) w_next = ST_READY;
         ST_READY: w_next = ST_READY;
      endcase
   end

   // Output decode
   always_comb begin
      w_ready   = (r_state == ST_READY);
      init_busy = ~w_ready;
   end

   assign w_last = (r_cnt == LAST);
   assign w_wr   = w_ready & wr_en & (wr_addr != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (!w_ready) begin
         r_cnt <= r_cnt + AW'(1);
      end
   end

   // Clear sequencer owns the write port until the file is ready
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (!w_ready) begin
            r_regs[r_cnt] <= '0;
         end else if (w_wr) begin
            r_regs[wr_addr] <= wr_data;
         end
      end
   end

   // A same-edge alloc beats the retiring write: a newer producer exists
   always_comb begin
      w_pend_nxt = r_pend;
      if (wr_en) w_pend_nxt[wr_addr] = 1'b0;
      if (alloc_en) w_pend_nxt[alloc_addr] = 1'b1;
      w_pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend <= '0;
      end else if (w_ready) begin
         r_pend <= w_pend_nxt;
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] w_a;
      logic          w_zero;
      logic          w_hit;

      assign w_a    = rd_addr[i*AW +: AW];
      assign w_zero = (w_a == '0) | ~w_ready;
      assign w_hit  = BYP & wr_en & (wr_addr == w_a);

      assign rd_data[i*XLEN +: XLEN] =
         w_zero ? '0 :
         w_hit  ? wr_data :
                  r_regs[w_a];

      assign rd_pending[i] = ~w_zero & r_pend[w_a] & ~w_hit;
   end

endmodule
